// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency 16-bit word memory responder with byte-lane writes and abortable requests.
// Optional address range checking is enabled by defining MEM_RESPONDER_RANGE_CHECK_EN.
module mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;

  logic [AW-1:0] r_idx;
  logic [15:0]   r_wdata;
  logic [1:0]    r_be;
  logic          r_wr;
  logic          r_err;
  logic [15:0]   r_rdata;
  logic [15:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_wr_bus;
  logic          w_err_bus;
  logic [AW-1:0] w_idx_bus;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_wr;
  logic          w_rd_err;
  logic          w_unused;

  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_wr_bus  = bus.mem_write & ~bus.mem_read;
  assign w_idx_bus = bus.mem_address[AW:1];
  assign w_unused  = ^{bus.mem_address[0], bus.mem_address};

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  assign w_err_bus   = |(bus.mem_address >> (AW + 1));
  assign bus.mem_err = (r_state == RESP) & r_err;
`else
  assign w_err_bus   = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  assign bus.mem_resp  = (r_state == RESP);
  assign bus.mem_rdata = r_rdata;

  // With LATENCY=1 RESP is entered straight from IDLE, so the read uses the live bus fields.
  assign w_rd_idx = (r_state == IDLE) ? w_idx_bus : r_idx;
  assign w_rd_wr  = (r_state == IDLE) ? w_wr_bus  : r_wr;
  assign w_rd_err = (r_state == IDLE) ? w_err_bus : r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_cnt_nxt   = 4'(LATENCY - 1);
          w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && w_req) begin
        r_idx   <= w_idx_bus;
        r_wdata <= bus.mem_wdata;
        r_be    <= bus.mem_byte_enable;
        r_wr    <= w_wr_bus;
        r_err   <= w_err_bus;
      end
      if (w_state_nxt == RESP && !w_rd_wr) begin
        r_rdata <= w_rd_err ? '0 : r_mem[w_rd_idx];
      end
    end
  end

  // Leaving RESP is gated by r_state, which reset clears asynchronously, so reset cancels the write.
  always_ff @(posedge clk) begin
    if (r_state == RESP && r_wr && !r_err) begin
      if (r_be[0]) r_mem[r_idx][7:0]  <= r_wdata[7:0];
      if (r_be[1]) r_mem[r_idx][15:8] <= r_wdata[15:8];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: transaction-level model checked every cycle plus literal expectations.
module tb_mem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_responder #(.DEPTH(DEPTH), .LATENCY(1))   dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model of dut (LATENCY=3) ----------------
  logic [15:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          m_phase = 0;   // cycles since acceptance; 0 = no transaction in flight
  bit          m_wr, m_err;
  int          m_idx;
  logic [15:0] m_wdata;
  logic [1:0]  m_be;
  logic [15:0] m_rdata = '0;
  bit          m_rdata_ok = 1'b1;

  function automatic bit range_bad(input logic [15:0] a);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    return int'(a) >= 2 * DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic load_rdata();
    if (m_wr) return;
    if (m_err) begin
      m_rdata    = '0;
      m_rdata_ok = 1'b1;
    end else begin
      m_rdata    = m_mem[m_idx];
      m_rdata_ok = m_known[m_idx];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit req;
    if (!rst_n) begin
      m_phase    = 0;
      m_rdata    = '0;
      m_rdata_ok = 1'b1;
    end else begin
      req = bus.mem_read || bus.mem_write;
      if (m_phase == 0) begin
        if (req) begin
          m_wr    = bus.mem_write && !bus.mem_read;
          m_idx   = (int'(bus.mem_address) % (2 * DEPTH)) / 2;
          m_err   = range_bad(bus.mem_address);
          m_wdata = bus.mem_wdata;
          m_be    = bus.mem_byte_enable;
          m_phase = 1;
          if (m_phase == LAT) load_rdata();
        end
      end else if (m_phase < LAT) begin
        if (!req) m_phase = 0;
        else begin
          m_phase++;
          if (m_phase == LAT) load_rdata();
        end
      end else begin
        if (m_wr && !m_err) begin
          if (m_be[0]) m_mem[m_idx][7:0]  = m_wdata[7:0];
          if (m_be[1]) m_mem[m_idx][15:8] = m_wdata[15:8];
          if (m_be == 2'b11) m_known[m_idx] = 1'b1;
        end
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_resp", {15'd0, bus.mem_resp}, {15'd0, (rst_n && m_phase == LAT)});
      chk("model_err",  {15'd0, bus.mem_err},  {15'd0, (rst_n && m_phase == LAT && m_err)});
      if (m_rdata_ok) chk("model_rdata", bus.mem_rdata, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Called at the start of a cycle (cycle 0); holds the request until mem_resp, then drops it.
  task automatic txn(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] be, output int lat, output logic [15:0] rdat, output logic err);
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = a;
    bus.mem_wdata = d; bus.mem_byte_enable = be;
    lat = -1; rdat = 'x; err = 1'bx;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        lat = n; rdat = bus.mem_rdata; err = bus.mem_err;
        break;
      end
    end
    step();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL txn_timeout addr=%h: no mem_resp within 20 cycles", a);
    end
  endtask

  int          lat;
  logic [15:0] rd;
  logic        er;

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0;
    bus.mem_wdata = '0;  bus.mem_byte_enable = '0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.mem_address = '0;
    bus1.mem_wdata = '0;  bus1.mem_byte_enable = '0;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_rdata",  bus.mem_rdata, 16'h0000);
    chk("reset_resp",   {15'd0, bus.mem_resp}, 16'h0000);
    chk("reset_err",    {15'd0, bus.mem_err},  16'h0000);
    chk("reset_rdata1", bus1.mem_rdata, 16'h0000);
    step();
    rst_n = 1'b1;
    step();

    txn(1'b0, 1'b1, 16'h0000, 16'h0F0F, 2'b11, lat, rd, er);
    chk("wr0_latency", 16'(lat), 16'd3);
    txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, rd, er);
    chk("wr_beef_latency", 16'(lat), 16'd3);
    txn(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b00, lat, rd, er);
    chk("rd_beef_latency", 16'(lat), 16'd3);
    chk("rd_beef_data", rd, 16'hBEEF);

    txn(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, lat, rd, er);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, er);
    chk("rd_lane0", rd, 16'hBE34);
    txn(1'b0, 1'b1, 16'h0010, 16'hAA00, 2'b10, lat, rd, er);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, er);
    chk("rd_lane1", rd, 16'hAA34);
    txn(1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, lat, rd, er);
    chk("wr_mask00_latency", 16'(lat), 16'd3);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, er);
    chk("rd_mask00", rd, 16'hAA34);

    txn(1'b1, 1'b1, 16'h0010, 16'h0000, 2'b11, lat, rd, er);
    chk("rdwr_data", rd, 16'hAA34);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, er);
    chk("rdwr_mem_kept", rd, 16'hAA34);

    // abort: read held in cycles 0-1, dropped in cycle 2
    bus.mem_read = 1'b1; bus.mem_address = 16'h0000;
    step(); step();
    bus.mem_read = 1'b0;
    @(negedge clk);
    chk("abort_resp",  {15'd0, bus.mem_resp}, 16'h0000);
    chk("abort_rdata", bus.mem_rdata, 16'hAA34);
    step();
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, lat, rd, er);
    chk("after_abort_latency", 16'(lat), 16'd3);
    chk("after_abort_data", rd, 16'h0F0F);

    // reset during BUSY of a write
    bus.mem_write = 1'b1; bus.mem_address = 16'h0010;
    bus.mem_wdata = 16'h5555; bus.mem_byte_enable = 2'b11;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_busy_resp",  {15'd0, bus.mem_resp}, 16'h0000);
    chk("rst_busy_rdata", bus.mem_rdata, 16'h0000);
    bus.mem_write = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, er);
    chk("rst_old_data", rd, 16'hAA34);

    // out-of-range address
    txn(1'b1, 1'b0, 16'h0400, 16'h0000, 2'b00, lat, rd, er);
    chk("oor_rd_latency", 16'(lat), 16'd3);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    chk("oor_rd_err",  {15'd0, er}, 16'h0001);
    chk("oor_rd_data", rd, 16'h0000);
`else
    chk("oor_rd_err",  {15'd0, er}, 16'h0000);
    chk("oor_rd_data", rd, 16'h0F0F);
`endif
    txn(1'b0, 1'b1, 16'h0400, 16'hDEAD, 2'b11, lat, rd, er);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, lat, rd, er);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    chk("oor_wr_blocked", rd, 16'h0F0F);
`else
    chk("oor_wr_wraps", rd, 16'hDEAD);
`endif

    // top word of the array
    txn(1'b0, 1'b1, 16'h01FF, 16'h7E7E, 2'b11, lat, rd, er);
    txn(1'b1, 1'b0, 16'h01FE, 16'h0000, 2'b00, lat, rd, er);
    chk("top_word", rd, 16'h7E7E);
    chk("top_word_err", {15'd0, er}, 16'h0000);

    // LATENCY=1 instance: write, then back-to-back reads on alternating cycles
    bus1.mem_write = 1'b1; bus1.mem_address = 16'h0002;
    bus1.mem_wdata = 16'h1357; bus1.mem_byte_enable = 2'b11;
    @(negedge clk);
    chk("l1_wr_c0", {15'd0, bus1.mem_resp}, 16'h0000);
    @(negedge clk);
    chk("l1_wr_c1", {15'd0, bus1.mem_resp}, 16'h0001);
    step();
    bus1.mem_write = 1'b0; bus1.mem_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("l1_rd_resp%0d", k), {15'd0, bus1.mem_resp}, {15'd0, k[0]});
      if (k[0]) chk($sformatf("l1_rd_data%0d", k), bus1.mem_rdata, 16'h1357);
    end
    step();
    bus1.mem_read = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
